// File: rtl/serial_rx_pkg.sv
// Shared types and default parameters for the serial receive framer.
// Pure declarations: no latency, no flow control.
package serial_rx_pkg;

    localparam int DEF_NUM_BITS     = 8;
    localparam int DEF_CLKS_PER_BIT = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period down-counter that strobes o_sample when it reaches zero while enabled; reloads on strobe or load.
// First strobe comes HALF (i_half) or CLKS_PER_BIT cycles after i_load; no backpressure, strobe is never held.
module rx_bit_timer
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_load,
    input  logic i_half,
    output logic o_sample
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] r_cnt;

    assign o_sample = i_en && (r_cnt == '0);

    // Parked at zero when disabled so nothing free-runs between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_half ? HALF_M1 : FULL_M1;
        end else if (o_sample) begin
            r_cnt <= FULL_M1;
        end else if (i_en) begin
            r_cnt <= r_cnt - 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/serial_rx_framer.sv
// Serial receive framer: start detect, mid-bit LSB-first sampling, stop check, word and status presentation.
// data_ready rises HALF+(NUM_BITS+1)*CLKS_PER_BIT+2 cycles after edge detect; no backpressure, unread words are overwritten and flagged as overrun.
module serial_rx_framer
    import serial_rx_pkg::*;
#(
    parameter int NUM_BITS     = DEF_NUM_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                data_read,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                framing_error,
    output logic                overrun_error,
    output logic                rx_busy
);

    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

    rx_state_t           r_state;
    logic [1:0]          r_sync;
    logic                r_s_prev;
    logic [NUM_BITS-1:0] r_shift;
    logic [BW-1:0]       r_bit_cnt;
    logic                r_stop;
    logic [NUM_BITS-1:0] r_rx_data;
    logic                r_data_ready;
    logic                r_framing;
    logic                r_overrun;
    logic                r_busy;

    logic w_s_in;
    logic w_edge;
    logic w_timer_en;
    logic w_timer_load;
    logic w_sample;

    assign w_s_in       = r_sync[1];
    assign w_edge       = r_s_prev & ~w_s_in;
    assign w_timer_en   = (r_state == START) || (r_state == DATA) || (r_state == STOP);
    assign w_timer_load = (r_state == IDLE) && w_edge;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_timer_en),
        .i_load  (w_timer_load),
        .i_half  (r_state == IDLE),
        .o_sample(w_sample)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_s_prev <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], serial_in};
            r_s_prev <= w_s_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '1;
            r_bit_cnt    <= '0;
            r_stop       <= 1'b0;
            r_rx_data    <= '0;
            r_data_ready <= 1'b0;
            r_framing    <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // A read acknowledges the held word; a LOAD in the same cycle overrides below.
            if (data_read) begin
                r_data_ready <= 1'b0;
                r_overrun    <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_sample) begin
                        if (!w_s_in) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_shift   <= {w_s_in, r_shift[NUM_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        r_stop  <= w_s_in;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_rx_data    <= r_shift;
                    r_data_ready <= 1'b1;
                    r_framing    <= ~r_stop;
                    r_overrun    <= r_data_ready & ~data_read;
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign framing_error = r_framing;
    assign overrun_error = r_overrun;
    assign rx_busy       = r_busy;

endmodule

// File: doc/serial_rx_framer.md
# serial_rx_framer

Serial receive framer: detects a start bit on an idle-high serial line, samples NUM_BITS data bits LSB-first at mid-bit, checks the stop bit, and presents the completed word with status flags. Sits directly upstream of the consumer logic as the front end of the serial receive path. It owns bit timing and framing; the consumer sees only `rx_data` plus handshake and status flags.

## Interface
- `NUM_BITS`, 8: data bits per frame, at least 2.
- `CLKS_PER_BIT`, 10: clk cycles per serial bit period, at least 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `serial_in`  in  1  raw serial line; idle is 1; asynchronous to `clk`.
- `data_read`  in  1  one-cycle pulse from the consumer acknowledging `rx_data`.
- `rx_data`  out  NUM_BITS  last received word.
- `data_ready`  out  1  `rx_data` holds an unacknowledged word.
- `framing_error`  out  1  stop bit of the last loaded frame was 0.
- `overrun_error`  out  1  a word was loaded while `data_ready` was still 1.
- `rx_busy`  out  1  a frame is in progress, i.e. the FSM is not in IDLE.

## Operation
- Synchronizer: `serial_in` passes through a 2-FF synchronizer, reset to 1. All logic uses the synchronized bit `s_in` and its one-cycle-delayed copy `s_prev`.
- FSM states:
  - IDLE: waits for a falling edge (`s_prev`=1, `s_in`=0) and goes to START. A line held low does not retrigger.
  - START: counts HALF = CLKS_PER_BIT/2 (floor) cycles, then samples `s_in`. If the sample is 0, go to DATA. If it is 1, treat it as a false start and return to IDLE with no flag.
  - DATA: samples every CLKS_PER_BIT cycles. Each sample shifts into the internal shift register from the MSB end (LSB-first line order). After NUM_BITS samples, go to STOP.
  - STOP: samples once after CLKS_PER_BIT cycles, latches the stop bit, then goes to LOAD.
  - LOAD: one cycle. Copies the shift register to `rx_data`, sets `data_ready`, sets `framing_error` to the inverse of the stop bit, and sets `overrun_error` if `data_ready` was 1 and `data_read` is 0. Then returns to IDLE.
- Framing errors: a frame with a bad stop bit is still loaded and flagged. `framing_error` is rewritten on every LOAD.
- `data_read` clears `data_ready` and `overrun_error`.
- `data_read` in the same cycle as LOAD: LOAD wins. `data_ready` stays 1 and `overrun_error` is not set.
- `data_read` while `data_ready`=0 has no effect.
- Bit-period counter: width $clog2(CLKS_PER_BIT). It reloads on each sample strobe and on entry to START. It is never free-running in IDLE.
- Bit counter: width $clog2(NUM_BITS+1). It clears on entry to DATA.

## Timing
- Reset values: `rx_data`=0, `data_ready`=0, `framing_error`=0, `overrun_error`=0, `rx_busy`=0. FSM goes to IDLE, synchronizer and shift register go to all 1s, and all counters go to 0.
- Let E be the cycle in which the edge is detected.
  - Start sample: E+HALF.
  - Data bit k (k = 0..NUM_BITS-1) sample: E+HALF+(k+1)·CLKS_PER_BIT.
  - Stop sample: E+HALF+(NUM_BITS+1)·CLKS_PER_BIT.
  - `data_ready` is first visible at E+HALF+(NUM_BITS+1)·CLKS_PER_BIT+2. For the defaults this is E+97.
- Pin-to-detection latency: 3 cycles (2-FF synchronizer plus the edge register).
- `rx_busy` rises the cycle after E and falls the cycle after LOAD.
- Status flags clear in the cycle after the `data_read` pulse.
- Outputs are registered, with no combinational path from inputs to outputs.
- `rst` asserted mid-frame: all outputs and state go to reset values immediately. No partial word is ever loaded.
- The next frame may start in the first cycle after LOAD.

## Structure
- Package `serial_rx_pkg` holds:
  - the state enum `rx_state_t` (IDLE, START, DATA, STOP, LOAD);
  - the default-constant localparams.
- Sub-module `rx_bit_timer` holds the bit-period counter. It has an enable/clear input and a one-cycle `sample` strobe output, parameterized by CLKS_PER_BIT and a half-period-mode input.
- The shift register, bit counter, and status registers live in the top module.

## Test plan
- **Nominal frame:** defaults, frame 0xA5 with stop bit 1 → `rx_data`=0xA5, `data_ready`=1 at E+97, `framing_error`=0, `overrun_error`=0.
- **False start:** line low for 3 cycles, then high → no `data_ready`, `rx_busy` drops after the start sample at E+5, FSM in IDLE.
- **Bad stop bit:** frame 0x3C with stop bit 0 → `rx_data`=0x3C, `data_ready`=1, `framing_error`=1. A following good frame 0x01 → `framing_error`=0.
- **Overrun:** frames 0x11 then 0x22 with no `data_read` → `rx_data`=0x22, `overrun_error`=1. A `data_read` pulse → `data_ready`=0 and `overrun_error`=0 next cycle.
- **Read collides with load:** `data_read` pulsed in the LOAD cycle of a second frame → `data_ready` stays 1, `overrun_error`=0.
- **Reset mid-frame:** `rst` pulsed during data bit 4 → all outputs 0 immediately. The next frame 0x7E is received correctly.
